mem_cs_sequencer: RTL and testbench

MEM_CS_SEQUENCER -- requirements
Module: mem_cs_sequencer

---
 rtl/mem_cs_sequencer.sv | 148 ++++++++++++++
 tb/tb_mem_cs_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cs_sequencer.sv
// rtl/mem_cs_sequencer.sv - chip-select / strobe sequencer with setup, wait-state, extension and hold phases
module mem_cs_sequencer #(
    parameter int SEL_WIDTH    = 3,
    parameter int WAIT_WIDTH   = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1,
    parameter int MAX_EXT      = 15,
    localparam int NUM_CHIPS   = 2 ** SEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  req,
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic                  rd_wr_,
    input  logic [WAIT_WIDTH-1:0] wait_cnt,
    input  logic                  wait_,
    output logic [NUM_CHIPS-1:0]  memorySelectors_,
    output logic                  oe_,
    output logic                  we_,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACTIVE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // One phase counter serves SETUP, ACTIVE and HOLD, so it must cover 15 and 2**WAIT_WIDTH-1.
    localparam int CNT_W = (WAIT_WIDTH > 4) ? WAIT_WIDTH : 4;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]       EXT_LIMIT  = 8'(MAX_EXT);

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [7:0]            ext_cnt, ext_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  rd_q, rd_d;
    logic [WAIT_WIDTH-1:0] wait_q, wait_d;
    logic                  timeout_q, timeout_d;
    logic                  done_d, err_d;
    logic [NUM_CHIPS-1:0]  cs_d;
    logic                  oe_d, we_d, busy_d;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state            <= IDLE;
            cnt              <= '0;
            ext_cnt          <= '0;
            sel_q            <= '0;
            rd_q             <= 1'b0;
            wait_q           <= '0;
            timeout_q        <= 1'b0;
            memorySelectors_ <= '1;
            oe_              <= 1'b1;
            we_              <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            ext_cnt          <= ext_d;
            sel_q            <= sel_d;
            rd_q             <= rd_d;
            wait_q           <= wait_d;
            timeout_q        <= timeout_d;
            memorySelectors_ <= cs_d;
            oe_              <= oe_d;
            we_              <= we_d;
            busy             <= busy_d;
            done             <= done_d;
            err              <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ext_d     = ext_cnt;
        sel_d     = sel_q;
        rd_d      = rd_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_d   = SETUP;
                    cnt_d     = '0;
                    ext_d     = '0;
                    timeout_d = 1'b0;
                    sel_d     = sel;
                    rd_d      = rd_wr_;
                    wait_d    = wait_cnt;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ACTIVE: begin
                // The counter parks on the last programmed cycle while the device extends.
                if (cnt != CNT_W'(wait_q)) begin
                    cnt_d = cnt + CNT_W'(1);
                end else if (!wait_ && (ext_cnt != EXT_LIMIT)) begin
                    ext_d = ext_cnt + 8'd1;
                end else begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    timeout_d = !wait_;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = timeout_q;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        cs_d   = '1;
        busy_d = (state_d != IDLE);
        oe_d   = !((state_d == ACTIVE) && rd_d);
        we_d   = !((state_d == ACTIVE) && !rd_d);
        if (state_d != IDLE) begin
            cs_d[sel_d] = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_cs_sequencer.sv
// tb/tb_mem_cs_sequencer.sv - scoreboard bench for mem_cs_sequencer
module tb_mem_cs_sequencer;

    typedef struct {
        logic [15:0] cs;
        int          cyc;
        int          oe;
        int          we;
        int          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        req = 1'b0;
    logic        req2 = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic        rd_wr_ = 1'b1;
    logic [3:0]  wait_cnt = 4'd0;
    logic        wait_ = 1'b1;

    logic [7:0]  cs1;
    logic        oe_, we_, busy, done, err;
    logic [15:0] cs2;
    logic        oe2_, we2_, busy2, done2, err2;

    int checks = 0;
    int errors = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    mem_cs_sequencer dut1 (
        .clk(clk), .reset_(reset_), .req(req), .sel(sel[2:0]), .rd_wr_(rd_wr_),
        .wait_cnt(wait_cnt), .wait_(wait_), .memorySelectors_(cs1),
        .oe_(oe_), .we_(we_), .busy(busy), .done(done), .err(err)
    );

    mem_cs_sequencer #(.SEL_WIDTH(4), .SETUP_CYCLES(2), .HOLD_CYCLES(3)) dut2 (
        .clk(clk), .reset_(reset_), .req(req2), .sel(sel), .rd_wr_(rd_wr_),
        .wait_cnt(wait_cnt), .wait_(wait_), .memorySelectors_(cs2),
        .oe_(oe2_), .we_(we2_), .busy(busy2), .done(done2), .err(err2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int which, input logic [15:0] cs, input int cyc,
                        input int oe, input int we, input int e);
        exp_t x;
        x.cs = cs; x.cyc = cyc; x.oe = oe; x.we = we; x.err = e;
        if (which == 1) q1.push_back(x);
        else q2.push_back(x);
    endtask

    // wait_ is low after accept-relative edges lo_from .. lo_to-1
    task automatic run(input int which, input logic [3:0] s, input logic rd, input logic [3:0] wc,
                       input int lo_from, input int lo_to);
        bit seen = 0;
        int k = 0;
        @(posedge clk); #1;
        sel = s; rd_wr_ = rd; wait_cnt = wc;
        if (which == 1) req = 1'b1; else req2 = 1'b1;
        @(posedge clk);
        while (!seen && k < 200) begin
            #1;
            if (k == 0) begin req = 1'b0; req2 = 1'b0; end
            wait_ = !(k >= lo_from && k < lo_to);
            if ((which == 1) ? done : done2) seen = 1;
            else begin @(posedge clk); k++; end
        end
        wait_ = 1'b1;
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    int m1_cyc = 0, m1_oe = 0, m1_we = 0, m1_var = 0;
    logic [15:0] m1_cs = '1;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset_) begin
            m1_cyc = 0; m1_oe = 0; m1_we = 0; m1_var = 0; m1_cs = '1;
        end else begin
            if (busy) begin
                if (m1_cyc == 0) m1_cs = {8'h00, cs1};
                else if ({8'h00, cs1} != m1_cs) m1_var = 1;
                m1_cyc++;
                if (!oe_) m1_oe++;
                if (!we_) m1_we++;
            end
            if (err && !done) chk("err_without_done1", 1, 0);
            if (done) begin
                if (q1.size() == 0) chk("unexpected_done1", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("cs1_value", int'(m1_cs), int'(e.cs));
                    chk("cs1_cycles", m1_cyc, e.cyc);
                    chk("oe1_cycles", m1_oe, e.oe);
                    chk("we1_cycles", m1_we, e.we);
                    chk("err1", int'(err), e.err);
                    chk("cs1_stable", m1_var, 0);
                    chk("cs1_idle_in_done", int'(cs1), 8'hFF);
                end
                m1_cyc = 0; m1_oe = 0; m1_we = 0; m1_var = 0;
            end
        end
    end

    int m2_cyc = 0, m2_oe = 0, m2_we = 0, m2_var = 0;
    logic [15:0] m2_cs = '1;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset_) begin
            m2_cyc = 0; m2_oe = 0; m2_we = 0; m2_var = 0; m2_cs = '1;
        end else begin
            if (busy2) begin
                if (m2_cyc == 0) m2_cs = cs2;
                else if (cs2 != m2_cs) m2_var = 1;
                m2_cyc++;
                if (!oe2_) m2_oe++;
                if (!we2_) m2_we++;
            end
            if (done2) begin
                if (q2.size() == 0) chk("unexpected_done2", 1, 0);
                else begin
                    e = q2.pop_front();
                    chk("cs2_value", int'(m2_cs), int'(e.cs));
                    chk("cs2_cycles", m2_cyc, e.cyc);
                    chk("oe2_cycles", m2_oe, e.oe);
                    chk("we2_cycles", m2_we, e.we);
                    chk("err2", int'(err2), e.err);
                    chk("cs2_stable", m2_var, 0);
                end
                m2_cyc = 0; m2_oe = 0; m2_we = 0; m2_var = 0;
            end
        end
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs1", int'(cs1), 8'hFF);
        chk("rst_cs2", int'(cs2), 16'hFFFF);
        chk("rst_strobes", int'({oe_, we_, busy, done, err}), 5'b11000);
        reset_ = 1'b1;

        push(1, 16'h00DF, 5, 3, 0, 0);
        run(1, 4'd5, 1'b1, 4'd2, 0, 0);
        push(1, 16'h00FE, 3, 0, 1, 0);
        run(1, 4'd0, 1'b0, 4'd0, 0, 0);
        push(1, 16'h00FB, 7, 5, 0, 0);
        run(1, 4'd2, 1'b1, 4'd1, 2, 5);
        push(1, 16'h007F, 19, 0, 17, 1);
        run(1, 4'd7, 1'b0, 4'd1, 0, 1000);
        push(1, 16'h00FD, 18, 16, 0, 0);
        run(1, 4'd1, 1'b1, 4'd15, 0, 0);

        push(1, 16'h00F7, 3, 1, 0, 0);
        push(1, 16'h00BF, 3, 1, 0, 0);
        @(posedge clk); #1;
        sel = 4'd3; rd_wr_ = 1'b1; wait_cnt = 4'd0; req = 1'b1;
        @(posedge clk); #1;
        sel = 4'd6;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("b2b_first_done", int'(seen), 1);
        @(posedge clk); #1;
        chk("b2b_restart_busy", int'(busy), 1);
        req = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("b2b_second_done", int'(seen), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_queued_req", int'(busy), 0);

        @(posedge clk); #1;
        sel = 4'd2; rd_wr_ = 1'b1; wait_cnt = 4'd5; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("pre_rst_oe_low", int'(oe_), 0);
        reset_ = 1'b0;
        #1;
        chk("async_rst_cs1", int'(cs1), 8'hFF);
        chk("async_rst_outs", int'({oe_, we_, busy, done, err}), 5'b11000);
        @(posedge clk); #1;
        reset_ = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || err) seen = 1;
        end
        chk("no_done_after_abort", int'(seen), 0);

        push(1, 16'h00EF, 4, 0, 2, 0);
        run(1, 4'd4, 1'b0, 4'd1, 0, 0);

        push(2, 16'h7FFF, 8, 3, 0, 0);
        run(2, 4'd15, 1'b1, 4'd2, 0, 0);
        push(2, 16'hFFFE, 6, 0, 1, 0);
        run(2, 4'd0, 1'b0, 4'd0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
